// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared constants and types for the RAM-backed FIFO controller.
//   ADDR_W / DATA_W : default RAM address and word widths (16 x 8 RAM)
//   cyc_e           : what the single RAM port is doing in a given cycle
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    CYC_IDLE = 2'd0,
    CYC_WR   = 2'd1,
    CYC_RD   = 2'd2
  } cyc_e;

endpackage : mem_pkg

// File: rtl/wrap_ctr.sv
// -----------------------------------------------------------------------------
// wrap_ctr
// Modulo-2**W pointer. It advances by one on each clock where i_inc is high.
// The wrap from 2**W-1 back to 0 comes from the natural overflow of the W-bit
// register, so no compare is needed.
//   clk   : clock
//   rst   : synchronous active-high reset, clears the pointer to 0
//   i_inc : advance the pointer at this edge
//   o_val : current pointer value
// -----------------------------------------------------------------------------
module wrap_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_val
);

  logic [W-1:0] r_val;

  // NOTE: sequential state is always written with non-blocking assignments so
  // that every register samples pre-edge values, whatever the process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= '0;
    end else if (i_inc) begin
      r_val <= r_val + 1'b1;
    end
  end

  assign o_val = r_val;

endmodule : wrap_ctr

// File: rtl/ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// ram_fifo_ctrl
// Turns a single-port RAM (combinational read) into a circular FIFO with a
// registered output word. Each cycle the RAM port performs one of idle, write
// or read. Refilling the output register (read) wins over accepting a new word
// (write).
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_data     : write stream in; in_ready is the accept strobe
//   out_valid/out_data   : registered head word; out_ready is the pop strobe
//   ram_addr/ram_we      : RAM port control
//   ram_wdata/ram_rdata  : RAM write data (= in_data) and combinational read data
//   count                : words held, RAM words plus the output register
//   full / empty         : RAM holds DEPTH words / nothing held at all
// -----------------------------------------------------------------------------
module ram_fifo_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W_P = mem_pkg::ADDR_W,
  parameter int DATA_W_P = mem_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W_P-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DATA_W_P-1:0] out_data,
  input  logic                out_ready,
  output logic [ADDR_W_P-1:0] ram_addr,
  output logic                ram_we,
  output logic [DATA_W_P-1:0] ram_wdata,
  input  logic [DATA_W_P-1:0] ram_rdata,
  output logic [ADDR_W_P:0]   count,
  output logic                full,
  output logic                empty
);

  localparam int                DEPTH   = 2 ** ADDR_W_P;
  localparam logic [ADDR_W_P:0] DEPTH_C = (ADDR_W_P + 1)'(DEPTH);

  logic [ADDR_W_P-1:0] w_wr_ptr;
  logic [ADDR_W_P-1:0] w_rd_ptr;
  logic [ADDR_W_P:0]   r_ram_count;
  logic                r_out_valid;
  logic [DATA_W_P-1:0] r_out_data;

  logic                w_out_free;
  logic                w_ram_full;
  logic                w_rd_go;
  logic                w_wr_go;
  cyc_e                w_cyc;

  // The output register can take a new word if it is empty or being popped now.
  assign w_out_free = !r_out_valid || out_ready;
  assign w_ram_full = (r_ram_count == DEPTH_C);

  // Both go signals are masked during reset so the pointers and the RAM
  // are left untouched while rst is high.
  assign w_rd_go = !rst && (r_ram_count != '0) && w_out_free;
  assign w_wr_go = !rst && !w_rd_go && in_valid && !w_ram_full;

  assign in_ready  = !rst && !w_rd_go && !w_ram_full;
  assign ram_wdata = in_data;

  // Port arbitration: pick the cycle kind, then decode the RAM pins from it.
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_cyc    = CYC_IDLE;
    ram_addr = w_wr_ptr;
    ram_we   = 1'b0;
    if (w_rd_go) begin
      w_cyc = CYC_RD;
    end else if (w_wr_go) begin
      w_cyc = CYC_WR;
    end
    case (w_cyc)
      CYC_RD: ram_addr = w_rd_ptr;
      CYC_WR: begin
        ram_addr = w_wr_ptr;
        ram_we   = 1'b1;
      end
      default: ram_addr = rst ? '0 : w_wr_ptr;
    endcase
  end

  wrap_ctr #(.W(ADDR_W_P)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wr_go),
    .o_val (w_wr_ptr)
  );

  wrap_ctr #(.W(ADDR_W_P)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_rd_go),
    .o_val (w_rd_ptr)
  );

  // NOTE: only control state is reset; the RAM itself is not cleared, because
  // zeroed pointers and count make any stale contents unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_count <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      // Read and write never share a cycle, so the count moves by at most one.
      if (w_rd_go) begin
        r_ram_count <= r_ram_count - 1'b1;
      end else if (w_wr_go) begin
        r_ram_count <= r_ram_count + 1'b1;
      end

      // A pop with a simultaneous refill keeps out_valid high.
      if (w_rd_go) begin
        r_out_valid <= 1'b1;
        r_out_data  <= ram_rdata;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Status is derived from registered state only.
  assign count = r_ram_count + {{ADDR_W_P{1'b0}}, r_out_valid};
  assign full  = w_ram_full;
  assign empty = (count == '0);

endmodule : ram_fifo_ctrl

// File: tb/tb_ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_fifo_ctrl
// Directed bench for ram_fifo_ctrl with a behavioural 16x8 single-port RAM
// (synchronous write, combinational read) attached to the RAM pins.
// -----------------------------------------------------------------------------
module tb_ram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic [4:0] count;
  logic       full;
  logic       empty;

  logic [7:0] mem [16];

  int n_vec = 0;
  int n_err = 0;

  ram_fifo_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and wait (bounded) until it is accepted.
  task automatic push(input logic [7:0] d);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int exp_idx;
    int snd_idx;
    int cyc;
    bit got;

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();

    // ---------------- reset state ----------------
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ram_we",   ram_we,   0);
    chk("rst_ram_addr", ram_addr, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready",  in_ready,  1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_out_data",  out_data,  0);
    chk("post_rst_count",     count,     0);
    chk("post_rst_full",      full,      0);
    chk("post_rst_empty",     empty,     1);

    // ---------------- single word latency ----------------
    in_valid = 1'b1;
    in_data  = 8'h11;
    #1;
    chk("w1_ram_we",   ram_we,   1);
    chk("w1_ram_addr", ram_addr, 0);
    chk("w1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("r1_ram_we",     ram_we,    0);
    chk("r1_ram_addr",   ram_addr,  0);
    chk("r1_out_valid",  out_valid, 0);
    chk("r1_count",      count,     1);
    tick();
    chk("o1_out_valid", out_valid, 1);
    chk("o1_out_data",  out_data,  8'h11);
    chk("o1_count",     count,     1);
    chk("o1_empty",     empty,     0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("o1_popped_empty", empty, 1);

    // ---------------- fill to 17 ----------------
    for (int i = 0; i <= 16; i++) push(8'(i));
    #1;
    chk("fill_full",     full,     1);
    chk("fill_count",    count,    17);
    chk("fill_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'h99;
    #1;
    chk("ovf_in_ready", in_ready, 0);
    chk("ovf_ram_we",   ram_we,   0);
    tick();
    in_valid = 1'b0;
    chk("ovf_count", count, 17);

    // ---------------- drain in order ----------------
    out_ready = 1'b1;
    exp_idx   = 0;
    for (int c = 0; c < 60 && exp_idx < 17; c++) begin
      #1;
      if (out_valid) begin
        chk("drain_data", out_data, 8'(exp_idx));
        exp_idx++;
      end
      tick();
    end
    chk("drain_n", exp_idx, 17);
    #1;
    chk("drain_empty", empty,     1);
    chk("drain_count", count,     0);
    chk("drain_full",  full,      0);
    chk("drain_ov",    out_valid, 0);

    // ---------------- simultaneous pop and refill ----------------
    out_ready = 1'b0;
    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    #1;
    chk("pr_count", count, 3);
    out_ready = 1'b1;
    #1;
    chk("pr1_in_ready",  in_ready,  0);
    chk("pr1_out_valid", out_valid, 1);
    chk("pr1_out_data",  out_data,  8'hA1);
    tick();
    chk("pr2_in_ready",  in_ready,  0);
    chk("pr2_out_valid", out_valid, 1);
    chk("pr2_out_data",  out_data,  8'hB2);
    tick();
    chk("pr3_in_ready",  in_ready,  1);
    chk("pr3_out_valid", out_valid, 1);
    chk("pr3_out_data",  out_data,  8'hC3);
    tick();
    chk("pr4_out_valid", out_valid, 0);
    chk("pr4_empty",     empty,     1);

    // ---------------- 40-word wrap with toggling out_ready ----------------
    exp_idx = 0;
    snd_idx = 0;
    cyc     = 0;
    while (exp_idx < 40 && cyc < 600) begin
      out_ready = cyc[0];
      in_valid  = (snd_idx < 40);
      in_data   = 8'h40 + 8'(snd_idx);
      #1;
      if (out_valid && out_ready) begin
        chk("wrap_data", out_data, 8'h40 + 8'(exp_idx));
        exp_idx++;
      end
      if (in_valid && in_ready) snd_idx++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("wrap_n", exp_idx, 40);
    #1;
    chk("wrap_empty", empty, 1);

    // ---------------- reset mid-stream ----------------
    for (int i = 0; i < 9; i++) push(8'h70 + 8'(i));
    #1;
    chk("mid_count", count, 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_count",     count,     0);
    chk("mid_rst_empty",     empty,     1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ram_we",    ram_we,    0);
    push(8'hA5);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (out_valid) begin
        chk("mid_first_word", out_data, 8'hA5);
        got = 1;
      end
      tick();
    end
    chk("mid_first_seen", got, 1);
    out_ready = 1'b0;
    #1;
    chk("mid_final_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ram_fifo_ctrl

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Streaming FIFO controller that sits directly upstream of the team's single-port 16x8 RAM and turns it into a 16-entry circular buffer. It accepts bytes on a valid/ready write stream, and drives the RAM's address, write-enable and write-data pins. It consumes the RAM's combinational read data into a one-word output register and presents it on a valid/ready read stream. Because the RAM has one address port, each cycle is exactly one of idle, write or read; the controller arbitrates.

## Interface
- ADDR_W, 4, RAM address width; RAM depth DEPTH = 2**ADDR_W.
- DATA_W, 8, word width.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  write-stream word present.
- in_data  in  DATA_W  write-stream word.
- in_ready  out  1  word accepted this cycle when in_valid && in_ready.
- out_valid  out  1  out_data holds a valid word.
- out_data  out  DATA_W  head-of-FIFO word (registered).
- out_ready  in  1  consumer takes out_data this cycle when out_valid && out_ready.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data (= in_data).
- ram_rdata  in  DATA_W  RAM read data, combinational from ram_addr.
- count  out  ADDR_W+1  words held, = ram_count + out_valid (0..DEPTH+1).
- full  out  1  ram_count == DEPTH.
- empty  out  1  count == 0.

## Operation
- State: wr_ptr, rd_ptr (ADDR_W, wrap modulo DEPTH), ram_count (ADDR_W+1, 0..DEPTH), out_valid, out_data.
- Output register is free when out_valid==0 or out_ready==1.
- Read cycle (rd_go): ram_count != 0 and output register free. ram_addr = rd_ptr, ram_we = 0. At the edge, out_data <= ram_rdata, out_valid <= 1, rd_ptr++, ram_count--.
- Write cycle (wr_go): not rd_go, in_valid, ram_count != DEPTH. ram_addr = wr_ptr, ram_we = 1. At the edge, RAM stores in_data, wr_ptr++, ram_count++.
- Read has priority over write. in_ready = !rd_go && !full; it is combinational from out_ready, out_valid and state.
- Idle cycle: ram_addr = wr_ptr, ram_we = 0.
- If out_valid && out_ready && !rd_go, then out_valid <= 0 at the edge.
- While out_valid && !out_ready, out_data is held stable.
- The upstream side holds in_data stable while in_valid && !in_ready.
- Pointers wrap from DEPTH-1 to 0 with no special case.
- No overflow: writes are impossible when full. No underflow: reads are impossible when ram_count == 0.
- Reset, including mid-stream:
  - wr_ptr, rd_ptr, ram_count, out_valid and out_data go to 0.
  - ram_we is 0 and ram_addr is 0 while rst is high.
  - in_ready is 0 while rst is high.
  - RAM contents are not cleared; stale data is unreachable.
- Reset values of outputs: in_ready 0 during reset and 1 after; out_valid 0; out_data 0; count 0; full 0; empty 1; ram_we 0; ram_addr 0.

## Timing
- Write-to-read latency when the FIFO is empty: word accepted at edge N. The read cycle occurs in cycle N+1, and out_valid is high from edge N+1 (visible in cycle N+2). Minimum latency is 2 cycles.
- Steady-state throughput is one word per two cycles with a single port. Burst write rate is 1/cycle while the output register is full and out_ready is 0.
- Simultaneous out_ready pop and rd_go: the output register is refilled in the same edge, so out_valid stays 1.
- Simultaneous in_valid and rd_go: in_ready is 0 that cycle and the write is deferred. A writer is never starved, because reads stop once ram_count reaches 0 or the output register is full.
- count, full and empty are registered-state derived, with no combinational path from in_valid or out_ready.

## Structure
- The shared package mem_pkg holds:
  - default ADDR_W and DATA_W constants;
  - a typedef enum for the port cycle kind: CYC_IDLE, CYC_WR, CYC_RD.
- One sub-module is natural: wrap_ctr, a parameterised modulo-DEPTH pointer with an inc input. It is instantiated twice, for wr_ptr and rd_ptr.

## Test plan
- Reset with out_ready=0, then write 0x11 with in_valid for 1 cycle: ram_we=1 and ram_addr=0 at the accept cycle. In the next cycle ram_addr=0 and ram_we=0 (read). After that, out_valid=1, out_data=0x11 and count=1.
- Hold out_ready=0 and stream 0x00..0x10 (17 words): the first word sits in the output register and 16 go to RAM. Then full=1, in_ready=0 and count=17; an 18th in_valid is not accepted.
- From that full state, set out_ready=1 with in_valid=0: 0x00..0x10 emerge in order. After the drain, empty=1 and ram_count=0.
- Wrap check: 40 words with out_ready toggling 1,0,1,0 are delivered in order with no loss or duplication, and pointers pass 15→0 at least twice.
- Simultaneous pop and refill: with 3 words held and out_ready=1 continuously, out_valid stays 1 across consecutive refill edges, and in_ready=0 on every rd_go cycle.
- Assert rst for 1 cycle mid-stream with count=9: the next cycle shows count=0, empty=1, out_valid=0 and ram_we=0. A subsequent write 0xA5 emerges as the first word out.
